rcc_clk_div_nch: RTL and testbench

//  Multi-channel integer clock divider, successor to the single-channel RCC divider.
//  CH_NUM independent dividers share one source clock, each with its own runtime ratio.
//  A valid/ready config port updates ratios glitch-free: a new ratio takes effect only
//  at a period boundary. Outputs feed downstream clock-gating and peripheral clock roots.

---
 rtl/rcc_clk_div_nch.sv | 155 +++++++++++++++
 tb/tb_rcc_clk_div_nch.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_clk_div_nch.sv
// rcc_clk_div_nch: multi-channel integer clock divider sharing one source clock.
// Each channel has its own runtime ratio. Ratio updates arrive over a valid/ready port.
// Updates are glitch-free: a running channel only switches ratio at a period boundary.
// Optional feature: define RCC_CLK_DIV_NCH_ALIGN_EN to add the `align` input. Pulsing it
// restarts every channel in phase.
module rcc_clk_div_nch #(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned RATIO_WID = 6,
  parameter int unsigned RST_RATIO = 0,
  localparam int unsigned CH_WID   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 i_clk,
  input  logic                 rst,
`ifdef RCC_CLK_DIV_NCH_ALIGN_EN
  input  logic                 align,
`endif
  input  logic                 cfg_vld,
  input  logic [CH_WID-1:0]    cfg_ch,
  input  logic [RATIO_WID-1:0] cfg_ratio,
  output logic                 cfg_rdy,
  output logic [CH_NUM-1:0]    o_clk,
  output logic [CH_NUM-1:0]    div_en,
  output logic [CH_NUM-1:0]    div_pulse
);

  localparam logic [RATIO_WID-1:0] RstRatio = RATIO_WID'(RST_RATIO);
  localparam logic [RATIO_WID-1:0] MinRatio = RATIO_WID'(2);
  localparam logic [RATIO_WID-1:0] One      = RATIO_WID'(1);
  localparam logic                 RstClk   = (RstRatio >= MinRatio);

  logic [RATIO_WID-1:0] act_q    [CH_NUM];
  logic [RATIO_WID-1:0] act_d    [CH_NUM];
  logic [RATIO_WID-1:0] cnt_q    [CH_NUM];
  logic [RATIO_WID-1:0] cnt_d    [CH_NUM];
  logic [RATIO_WID-1:0] pend_r_q [CH_NUM];
  logic [RATIO_WID-1:0] pend_r_d [CH_NUM];
  logic [CH_NUM-1:0]    pend_q, pend_d;
  logic [CH_NUM-1:0]    clk_q, clk_d;
  logic [CH_NUM-1:0]    pulse_q, pulse_d;
  logic                 ch_ok;
  logic                 accept;

  // Config handshake: a channel with an update already queued back-pressures the port.
  // Requests to nonexistent channels are acknowledged and dropped.
  always_comb begin
    ch_ok   = 32'(cfg_ch) < CH_NUM;
    cfg_rdy = 1'b1;
    if (ch_ok) begin
      cfg_rdy = ~pend_q[cfg_ch];
    end
    accept = cfg_vld & cfg_rdy & ch_ok;
  end

  // Channel is dividing whenever its active ratio is at least 2.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      div_en[c] = (act_q[c] >= MinRatio);
    end
  end

  // Per-channel next state: count within a period, apply ratio changes only at the wrap.
  always_comb begin
    logic                 hit;
    logic                 en;
    logic                 wrap;
    logic                 en_n;
    logic [RATIO_WID-1:0] hi_n;
    hit  = 1'b0;
    en   = 1'b0;
    wrap = 1'b0;
    en_n = 1'b0;
    hi_n = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      hit  = accept && (32'(cfg_ch) == c);
      en   = (act_q[c] >= MinRatio);
      wrap = en && (cnt_q[c] == act_q[c] - One);

      act_d[c]    = act_q[c];
      cnt_d[c]    = cnt_q[c];
      pend_d[c]   = pend_q[c];
      pend_r_d[c] = pend_r_q[c];

      if (!en) begin
        // Idle channel takes a new ratio immediately, starting at the top of a high phase.
        cnt_d[c] = '0;
        if (hit) begin
          act_d[c] = cfg_ratio;
        end
      end else if (wrap) begin
        // Boundary: a same-cycle request beats the queued one (it cannot coexist anyway).
        cnt_d[c]  = '0;
        pend_d[c] = 1'b0;
        if (hit) begin
          act_d[c] = cfg_ratio;
        end else if (pend_q[c]) begin
          act_d[c] = pend_r_q[c];
        end
      end else begin
        cnt_d[c] = cnt_q[c] + One;
        if (hit) begin
          pend_d[c]   = 1'b1;
          pend_r_d[c] = cfg_ratio;
        end
      end

`ifdef RCC_CLK_DIV_NCH_ALIGN_EN
      // Align forces a boundary on every channel at once.
      if (align) begin
        cnt_d[c]  = '0;
        pend_d[c] = 1'b0;
        if (hit) begin
          act_d[c] = cfg_ratio;
        end else if (pend_q[c]) begin
          act_d[c] = pend_r_q[c];
        end else begin
          act_d[c] = act_q[c];
        end
      end
`endif

      // Outputs are registered copies of the decode of the next count.
      en_n       = (act_d[c] >= MinRatio);
      hi_n       = act_d[c] - (act_d[c] >> 1);
      clk_d[c]   = en_n && (cnt_d[c] < hi_n);
      pulse_d[c] = en_n && (cnt_d[c] == act_d[c] - One);
    end
  end

  // State registers; asynchronous reset discards any queued update.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        act_q[c]    <= RstRatio;
        cnt_q[c]    <= '0;
        pend_r_q[c] <= '0;
      end
      pend_q  <= '0;
      clk_q   <= {CH_NUM{RstClk}};
      pulse_q <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        act_q[c]    <= act_d[c];
        cnt_q[c]    <= cnt_d[c];
        pend_r_q[c] <= pend_r_d[c];
      end
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_clk     = clk_q;
  assign div_pulse = pulse_q;

endmodule

// File: tb/tb_rcc_clk_div_nch.sv
// Bench for rcc_clk_div_nch: randomized and directed stimulus against a period-level model.
module tb_rcc_clk_div_nch;

  localparam int CH = 4;

  logic       i_clk = 1'b0;
  logic       rst;
  logic       align;
  logic       cfg_vld;
  logic [1:0] cfg_ch;
  logic [5:0] cfg_ratio;
  logic       cfg_rdy;
  logic [3:0] o_clk;
  logic [3:0] div_en;
  logic [3:0] div_pulse;

  int checks = 0;
  int errors = 0;

  // Model: per channel the active ratio, cycles elapsed in the current period,
  // and the queued ratio if any.
  int   m_r  [CH];
  int   m_t  [CH];
  int   m_pr [CH];
  bit   m_pv [CH];
  logic [3:0] exp_clk, exp_pulse, exp_en;

  rcc_clk_div_nch dut (
    .i_clk     (i_clk),
    .rst       (rst),
`ifdef RCC_CLK_DIV_NCH_ALIGN_EN
    .align     (align),
`endif
    .cfg_vld   (cfg_vld),
    .cfg_ch    (cfg_ch),
    .cfg_ratio (cfg_ratio),
    .cfg_rdy   (cfg_rdy),
    .o_clk     (o_clk),
    .div_en    (div_en),
    .div_pulse (div_pulse)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Waveform of a channel: high for the first ceil(R/2) cycles of each R-cycle period,
  // strobe on the last cycle.
  task automatic model_out();
    for (int c = 0; c < CH; c++) begin
      exp_en[c]    = (m_r[c] >= 2);
      exp_clk[c]   = (m_r[c] >= 2) && (m_t[c] < (m_r[c] + 1) / 2);
      exp_pulse[c] = (m_r[c] >= 2) && (m_t[c] == m_r[c] - 1);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_r[c]  = 0;
      m_t[c]  = 0;
      m_pr[c] = 0;
      m_pv[c] = 1'b0;
    end
    model_out();
  endtask

  // One rising edge: DUT and model both consume the inputs currently driven.
  task automatic tick();
    bit acc;
    bit al;
    bit hit;
    acc = cfg_vld && !m_pv[cfg_ch];
    al  = align;
    @(posedge i_clk);
    for (int c = 0; c < CH; c++) begin
      hit = acc && (int'(cfg_ch) == c);
      if (al) begin
        if (hit) m_r[c] = int'(cfg_ratio);
        else if (m_pv[c]) m_r[c] = m_pr[c];
        m_pv[c] = 1'b0;
        m_t[c]  = 0;
      end else if (m_r[c] < 2) begin
        if (hit) m_r[c] = int'(cfg_ratio);
        m_t[c] = 0;
      end else if (m_t[c] == m_r[c] - 1) begin
        if (hit) m_r[c] = int'(cfg_ratio);
        else if (m_pv[c]) m_r[c] = m_pr[c];
        m_pv[c] = 1'b0;
        m_t[c]  = 0;
      end else begin
        m_t[c] = m_t[c] + 1;
        if (hit) begin
          m_pv[c] = 1'b1;
          m_pr[c] = int'(cfg_ratio);
        end
      end
    end
    #1;
    model_out();
  endtask

  task automatic test_reset();
    rst = 1'b1; align = 1'b0; cfg_vld = 1'b0; cfg_ch = 2'd0; cfg_ratio = 6'd0;
    repeat (3) @(posedge i_clk);
    #1;
    model_reset();
    if (o_clk !== 4'b0 || div_en !== 4'b0 || div_pulse !== 4'b0) begin
      errors++;
      $display("FAIL reset_out: o_clk=%b en=%b pulse=%b, want all 0", o_clk, div_en, div_pulse);
    end
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: cfg_rdy=%b, want 1", cfg_rdy);
    end
    checks++;
    @(negedge i_clk);
    rst = 1'b0;
    tick();
    if (o_clk !== exp_clk || div_en !== exp_en || div_pulse !== exp_pulse) begin
      errors++;
      $display("FAIL reset_idle: o_clk=%b/%b en=%b/%b pulse=%b/%b (got/want)",
               o_clk, exp_clk, div_en, exp_en, div_pulse, exp_pulse);
    end
    checks++;
  endtask

  task automatic test_ratio4();
    cfg_vld = 1'b1; cfg_ch = 2'd0; cfg_ratio = 6'd4;
    #1;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL r4_rdy: cfg_rdy=%b, want 1", cfg_rdy);
    end
    checks++;
    tick();
    cfg_vld = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (o_clk[0] !== ((k % 4) < 2) || div_pulse[0] !== ((k % 4) == 3)) begin
        errors++;
        $display("FAIL r4_pattern k=%0d: o_clk0=%b pulse0=%b, want %b %b",
                 k, o_clk[0], div_pulse[0], ((k % 4) < 2), ((k % 4) == 3));
      end
      checks++;
      if (o_clk !== exp_clk || div_en !== exp_en || div_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL r4_model k=%0d: o_clk=%b/%b en=%b/%b pulse=%b/%b (got/want)",
                 k, o_clk, exp_clk, div_en, exp_en, div_pulse, exp_pulse);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_ratio5();
    cfg_vld = 1'b1; cfg_ch = 2'd1; cfg_ratio = 6'd5;
    tick();
    cfg_vld = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (o_clk[1] !== ((k % 5) < 3) || div_en[1] !== 1'b1) begin
        errors++;
        $display("FAIL r5_pattern k=%0d: o_clk1=%b en1=%b, want %b 1",
                 k, o_clk[1], div_en[1], ((k % 5) < 3));
      end
      checks++;
      if (o_clk !== exp_clk || div_en !== exp_en || div_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL r5_model k=%0d: o_clk=%b/%b en=%b/%b pulse=%b/%b (got/want)",
                 k, o_clk, exp_clk, div_en, exp_en, div_pulse, exp_pulse);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_midchange();
    int n;
    n = 0;
    while (m_t[0] != 1 && n < 10) begin
      tick();
      n++;
    end
    cfg_vld = 1'b1; cfg_ch = 2'd0; cfg_ratio = 6'd6;
    tick();
    n = 0;
    while (m_pv[0] && n < 10) begin
      if (cfg_rdy !== 1'b0) begin
        errors++;
        $display("FAIL mid_rdy n=%0d: cfg_rdy=%b, want 0 while update queued", n, cfg_rdy);
      end
      checks++;
      if (o_clk !== exp_clk || div_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL mid_hold n=%0d: o_clk=%b/%b pulse=%b/%b (got/want)",
                 n, o_clk, exp_clk, div_pulse, exp_pulse);
      end
      checks++;
      tick();
      n++;
    end
    cfg_vld = 1'b0;
    if (n >= 10) begin
      errors++;
      $display("FAIL mid_timeout: queued update never reached a boundary");
    end
    checks++;
    for (int k = 0; k < 12; k++) begin
      if (o_clk[0] !== ((k % 6) < 3) || div_pulse[0] !== ((k % 6) == 5)) begin
        errors++;
        $display("FAIL mid_pattern k=%0d: o_clk0=%b pulse0=%b, want %b %b",
                 k, o_clk[0], div_pulse[0], ((k % 6) < 3), ((k % 6) == 5));
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_disable();
    int n;
    cfg_vld = 1'b1; cfg_ch = 2'd2; cfg_ratio = 6'd3;
    tick();
    cfg_vld = 1'b0;
    n = 0;
    while (m_t[2] != 1 && n < 10) begin
      tick();
      n++;
    end
    cfg_vld = 1'b1; cfg_ch = 2'd2; cfg_ratio = 6'd1;
    tick();
    cfg_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (o_clk !== exp_clk || div_en !== exp_en || div_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL dis_model k=%0d: o_clk=%b/%b en=%b/%b pulse=%b/%b (got/want)",
                 k, o_clk, exp_clk, div_en, exp_en, div_pulse, exp_pulse);
      end
      checks++;
      tick();
    end
    if (o_clk[2] !== 1'b0 || div_en[2] !== 1'b0 || div_pulse[2] !== 1'b0) begin
      errors++;
      $display("FAIL dis_final: o_clk2=%b en2=%b pulse2=%b, want 0 0 0",
               o_clk[2], div_en[2], div_pulse[2]);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    cfg_vld = 1'b1; cfg_ch = 2'd3; cfg_ratio = 6'd2;
    tick();
    cfg_ratio = 6'd7;
    tick();
    cfg_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    if (o_clk !== 4'b0 || div_en !== 4'b0 || div_pulse !== 4'b0) begin
      errors++;
      $display("FAIL arst_out: o_clk=%b en=%b pulse=%b, want all 0", o_clk, div_en, div_pulse);
    end
    checks++;
    @(negedge i_clk);
    rst = 1'b0;
    cfg_ch = 2'd3;
    #1;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL arst_rdy: cfg_rdy=%b, want 1 (queued update discarded)", cfg_rdy);
    end
    checks++;
    tick();
    if (o_clk !== exp_clk || div_en !== exp_en) begin
      errors++;
      $display("FAIL arst_after: o_clk=%b/%b en=%b/%b (got/want)", o_clk, exp_clk, div_en, exp_en);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cfg_vld = 1'($urandom_range(0, 1));
      cfg_ch  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cfg_ratio = 6'($urandom_range(0, 63));
      else cfg_ratio = 6'($urandom_range(0, 9));
`ifdef RCC_CLK_DIV_NCH_ALIGN_EN
      align = ($urandom_range(0, 19) == 0);
`endif
      #1;
      if (cfg_rdy !== !m_pv[cfg_ch]) begin
        errors++;
        $display("FAIL rnd_rdy i=%0d ch=%0d: cfg_rdy=%b, want %b", i, cfg_ch, cfg_rdy,
                 !m_pv[cfg_ch]);
      end
      checks++;
      tick();
      if (o_clk !== exp_clk || div_en !== exp_en || div_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL rnd_model i=%0d: o_clk=%b/%b en=%b/%b pulse=%b/%b (got/want)",
                 i, o_clk, exp_clk, div_en, exp_en, div_pulse, exp_pulse);
      end
      checks++;
    end
    cfg_vld = 1'b0;
    align   = 1'b0;
  endtask

`ifdef RCC_CLK_DIV_NCH_ALIGN_EN
  task automatic test_align();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge i_clk);
    rst = 1'b0;
    cfg_vld = 1'b1; cfg_ch = 2'd0; cfg_ratio = 6'd4;
    tick();
    cfg_vld = 1'b0;
    tick();
    cfg_vld = 1'b1; cfg_ch = 2'd1; cfg_ratio = 6'd6;
    tick();
    cfg_vld = 1'b0;
    repeat (3) tick();
    align = 1'b1;
    tick();
    align = 1'b0;
    if (o_clk[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL align_rise: o_clk[1:0]=%b, want 11", o_clk[1:0]);
    end
    checks++;
    for (int k = 0; k < 12; k++) begin
      if (o_clk !== exp_clk || div_en !== exp_en || div_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL align_model k=%0d: o_clk=%b/%b en=%b/%b pulse=%b/%b (got/want)",
                 k, o_clk, exp_clk, div_en, exp_en, div_pulse, exp_pulse);
      end
      checks++;
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ratio4();
    test_ratio5();
    test_midchange();
    test_disable();
    test_async_reset();
    test_random();
`ifdef RCC_CLK_DIV_NCH_ALIGN_EN
    test_align();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
